syn_sram_acc_arb: RTL and testbench

Arbiter and access sequencer for the single external 256K×16 async SRAM. It shares the SRAM between two requesters:
- the VGA line-buffer read port, which is real-time and high priority;
- the GPU read/write port.

The block drives the SRAM pins with registered strobes and returns read data with fixed latency. It sits between the VGA driver / GPU pixel engines and the SRAM pads.

---
 rtl/syn_global_pkg.sv | 8 +
 rtl/syn_sram_arb_prio.sv | 40 ++++
 rtl/syn_sram_acc_arb.sv | 127 ++++++++++++
 tb/tb_syn_sram_acc_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_global_pkg.sv
// rtl/syn_global_pkg.sv - shared SRAM geometry defaults and arbiter enums
package syn_global_pkg;
    localparam int P_SRAM_ADDR_W = 18;
    localparam int P_SRAM_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ACC, CAP} sram_arb_fsm_t;
    typedef enum logic {SRC_VGA, SRC_GPU} sram_arb_src_t;
endpackage

// File: rtl/syn_sram_arb_prio.sv
// rtl/syn_sram_arb_prio.sv - VGA-first grant decision; SYN_SRAM_ARB_STARVE_GUARD_EN adds the GPU starvation counter
module syn_sram_arb_prio #(
    parameter int P_VGA_BURST_MAX = 8
) (
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic slot,
    input  logic vga_req,
    input  logic gpu_req,
    output logic vga_gnt,
    output logic gpu_gnt
);
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(P_VGA_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_VGA_BURST_MAX);

    logic [CNT_W-1:0] cnt;
    logic             force_gpu;

    // Once VGA has taken P_VGA_BURST_MAX slots past a waiting GPU, the next slot is the GPU's.
    assign force_gpu = gpu_req && (cnt == CNT_MAX);
    assign vga_gnt   = slot && vga_req && !force_gpu;
    assign gpu_gnt   = slot && gpu_req && (!vga_req || force_gpu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (gpu_gnt || !gpu_req) begin
            cnt <= '0;
        end else if (vga_gnt && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign vga_gnt = slot && vga_req;
    assign gpu_gnt = slot && gpu_req && !vga_req;
`endif
endmodule

// File: rtl/syn_sram_acc_arb.sv
// rtl/syn_sram_acc_arb.sv - async SRAM arbiter/sequencer for VGA and GPU; optional SYN_SRAM_ARB_STARVE_GUARD_EN
module syn_sram_acc_arb #(
    parameter int P_SRAM_ADDR_W   = syn_global_pkg::P_SRAM_ADDR_W,
    parameter int P_SRAM_DATA_W   = syn_global_pkg::P_SRAM_DATA_W,
    parameter int P_VGA_BURST_MAX = 8
) (
    input  logic                     clk_ir,
    input  logic                     rst_il,
    input  logic                     vga_rd_en_i,
    input  logic [P_SRAM_ADDR_W-1:0] vga_addr_i,
    output logic                     vga_rdy_o,
    output logic                     vga_rd_valid_o,
    output logic [P_SRAM_DATA_W-1:0] vga_rd_data_o,
    input  logic                     gpu_en_i,
    input  logic                     gpu_wr_i,
    input  logic [P_SRAM_ADDR_W-1:0] gpu_addr_i,
    input  logic [P_SRAM_DATA_W-1:0] gpu_wdata_i,
    output logic                     gpu_rdy_o,
    output logic                     gpu_rd_valid_o,
    output logic [P_SRAM_DATA_W-1:0] gpu_rd_data_o,
    output logic [P_SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [P_SRAM_DATA_W-1:0] sram_dq_o,
    output logic                     sram_dq_oe_o,
    input  logic [P_SRAM_DATA_W-1:0] sram_dq_i,
    output logic                     sram_ce_n_o,
    output logic                     sram_oe_n_o,
    output logic                     sram_we_n_o,
    output logic                     sram_lb_n_o,
    output logic                     sram_ub_n_o
);
    import syn_global_pkg::*;

    sram_arb_fsm_t state_q, state_d;
    sram_arb_src_t src_q;
    logic          wr_q;
    logic          slot, accept, acc_wr;

    // Reset gates the accept window so rdy drops immediately, not at the next edge.
    assign slot   = rst_il && (state_q != ACC);
    assign accept = vga_rdy_o || gpu_rdy_o;
    assign acc_wr = gpu_rdy_o && gpu_wr_i;

    syn_sram_arb_prio #(
        .P_VGA_BURST_MAX(P_VGA_BURST_MAX)
    ) u_prio (
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
        .clk    (clk_ir),
        .rst_n  (rst_il),
`endif
        .slot   (slot),
        .vga_req(vga_rd_en_i),
        .gpu_req(gpu_en_i),
        .vga_gnt(vga_rdy_o),
        .gpu_gnt(gpu_rdy_o)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACC;
            ACC:     state_d = CAP;
            CAP:     state_d = accept ? ACC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            src_q          <= SRC_VGA;
            wr_q           <= 1'b0;
            sram_addr_o    <= '0;
            sram_dq_o      <= '0;
            sram_dq_oe_o   <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_lb_n_o    <= 1'b1;
            sram_ub_n_o    <= 1'b1;
            vga_rd_valid_o <= 1'b0;
            gpu_rd_valid_o <= 1'b0;
            vga_rd_data_o  <= '0;
            gpu_rd_data_o  <= '0;
        end else begin
            vga_rd_valid_o <= 1'b0;
            gpu_rd_valid_o <= 1'b0;
            // The edge closing a read ACC samples the pad and routes it back to its issuer.
            if (state_q == ACC && !wr_q) begin
                if (src_q == SRC_VGA) begin
                    vga_rd_valid_o <= 1'b1;
                    vga_rd_data_o  <= sram_dq_i;
                end else begin
                    gpu_rd_valid_o <= 1'b1;
                    gpu_rd_data_o  <= sram_dq_i;
                end
            end
            if (accept) begin
                src_q        <= vga_rdy_o ? SRC_VGA : SRC_GPU;
                wr_q         <= acc_wr;
                sram_addr_o  <= vga_rdy_o ? vga_addr_i : gpu_addr_i;
                if (acc_wr) sram_dq_o <= gpu_wdata_i;
                sram_dq_oe_o <= acc_wr;
                sram_ce_n_o  <= 1'b0;
                sram_lb_n_o  <= 1'b0;
                sram_ub_n_o  <= 1'b0;
                sram_oe_n_o  <= acc_wr;
                sram_we_n_o  <= !acc_wr;
            end else if (state_q == ACC) begin
                // Entering CAP: strobes release, address and write data hold.
                sram_ce_n_o  <= 1'b1;
                sram_lb_n_o  <= 1'b1;
                sram_ub_n_o  <= 1'b1;
                sram_oe_n_o  <= 1'b1;
                sram_we_n_o  <= 1'b1;
            end else begin
                sram_dq_oe_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// tb/tb_syn_sram_acc_arb.sv - self-checking bench for syn_sram_acc_arb with SRAM model and reference scoreboard
module tb_syn_sram_acc_arb;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int BM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_en, vga_rdy, vga_val;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          gpu_en, gpu_wr, gpu_rdy, gpu_val;
    logic [AW-1:0] gpu_addr;
    logic [DW-1:0] gpu_wdata, gpu_data;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_dq, s_dq_in;
    logic          s_oe, ce_n, oe_n, we_n, lb_n, ub_n;

    always #5 clk = ~clk;

    syn_sram_acc_arb dut (
        .clk_ir(clk), .rst_il(rst_n),
        .vga_rd_en_i(vga_en), .vga_addr_i(vga_addr), .vga_rdy_o(vga_rdy),
        .vga_rd_valid_o(vga_val), .vga_rd_data_o(vga_data),
        .gpu_en_i(gpu_en), .gpu_wr_i(gpu_wr), .gpu_addr_i(gpu_addr), .gpu_wdata_i(gpu_wdata),
        .gpu_rdy_o(gpu_rdy), .gpu_rd_valid_o(gpu_val), .gpu_rd_data_o(gpu_data),
        .sram_addr_o(s_addr), .sram_dq_o(s_dq), .sram_dq_oe_o(s_oe), .sram_dq_i(s_dq_in),
        .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n),
        .sram_lb_n_o(lb_n), .sram_ub_n_o(ub_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW-1:0] pad [int];
    logic [DW-1:0] ref_mem [int];

    typedef struct {bit src; logic [DW-1:0] data; int due;} rd_t;
    rd_t sb[$];

    int            la_cycle = -1000;
    bit            la_wr;
    logic [AW-1:0] la_addr;
    logic [DW-1:0] la_data;
    int            streak = 0;
    bit            acc_v, acc_g;
    int            n_vacc = 0, n_gacc = 0, n_vval = 0, n_we_low = 0, n_oe_hi = 0;

    function automatic logic [DW-1:0] pattern(logic [AW-1:0] a);
        return (a[15:0] * 16'h9E37) ^ {14'h0, a[17:16]};
    endfunction

    function automatic logic [DW-1:0] pad_rd(logic [AW-1:0] a);
        return pad.exists(int'(a)) ? pad[int'(a)] : pattern(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
    endfunction

    // SRAM pad model: writes land on the edge closing a write strobe, reads settle mid-cycle.
    always @(posedge clk) if (!ce_n && !we_n && s_oe) pad[int'(s_addr)] = s_dq;
    always @(negedge clk) s_dq_in = (!ce_n && !oe_n) ? pad_rd(s_addr) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit win, force_g, ev, eg, exp_vv, exp_gv;
        @(negedge clk);
        win     = (cyc != la_cycle + 1);
        force_g = 1'b0;
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
        force_g = gpu_en && (streak >= BM);
`endif
        ev = win && vga_en && !force_g;
        eg = win && gpu_en && (!vga_en || force_g);
        chk("vga_rdy", {31'b0, vga_rdy}, {31'b0, ev});
        chk("gpu_rdy", {31'b0, gpu_rdy}, {31'b0, eg});
        if (ev || eg) begin
            la_cycle = cyc;
            la_wr    = eg && gpu_wr;
            la_addr  = ev ? vga_addr : gpu_addr;
            la_data  = gpu_wdata;
            if (la_wr) ref_mem[int'(la_addr)] = gpu_wdata;
            else sb.push_back('{ev ? 1'b0 : 1'b1, ref_rd(la_addr), cyc + 2});
        end
        if (eg || !gpu_en) streak = 0;
        else if (ev) streak++;
        acc_v = ev; acc_g = eg;
        n_vacc += int'(ev); n_gacc += int'(eg);
        @(posedge clk); #1;
        cyc++;
        exp_vv = sb.size() > 0 && sb[0].due == cyc && sb[0].src == 1'b0;
        exp_gv = sb.size() > 0 && sb[0].due == cyc && sb[0].src == 1'b1;
        chk("vga_valid", {31'b0, vga_val}, {31'b0, exp_vv});
        chk("gpu_valid", {31'b0, gpu_val}, {31'b0, exp_gv});
        if (exp_vv) chk("vga_data", {16'b0, vga_data}, {16'b0, sb[0].data});
        if (exp_gv) chk("gpu_data", {16'b0, gpu_data}, {16'b0, sb[0].data});
        if (exp_vv || exp_gv) void'(sb.pop_front());
        n_vval += int'(vga_val);
        n_we_low += int'(!we_n);
        n_oe_hi += int'(s_oe);
        if (cyc == la_cycle + 1) begin
            chk("acc_ce_n", {31'b0, ce_n}, 0);
            chk("acc_lb_ub", {30'b0, lb_n, ub_n}, 0);
            chk("acc_oe_n", {31'b0, oe_n}, {31'b0, la_wr});
            chk("acc_we_n", {31'b0, we_n}, {31'b0, !la_wr});
            chk("acc_dq_oe", {31'b0, s_oe}, {31'b0, la_wr});
            chk("acc_addr", {14'b0, s_addr}, {14'b0, la_addr});
            if (la_wr) chk("acc_dq", {16'b0, s_dq}, {16'b0, la_data});
        end else begin
            chk("idle_we_n", {31'b0, we_n}, 1);
            chk("idle_oe_n", {31'b0, oe_n}, 1);
            chk("cap_dq_oe", {31'b0, s_oe}, {31'b0, (cyc == la_cycle + 2) && la_wr});
            if (cyc == la_cycle + 2) chk("cap_addr", {14'b0, s_addr}, {14'b0, la_addr});
        end
    endtask

    initial begin
        int i, t, v0, g0;
        logic [DW-1:0] old;
        pad[16]     = 16'hA5A5;
        ref_mem[16] = 16'hA5A5;
        rst_n = 1'b0;
        vga_en = 1'b1; gpu_en = 1'b1; gpu_wr = 1'b0;
        vga_addr = '0; gpu_addr = '0; gpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vga_rdy", {31'b0, vga_rdy}, 0);
        chk("rst_gpu_rdy", {31'b0, gpu_rdy}, 0);
        chk("rst_strobes", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
        chk("rst_addr", {14'b0, s_addr}, 0);
        chk("rst_dq", {15'b0, s_dq, s_oe}, 0);
        chk("rst_valids", {30'b0, vga_val, gpu_val}, 0);
        chk("rst_rdata", {vga_data, gpu_data}, 0);
        vga_en = 1'b0; gpu_en = 1'b0;
        rst_n = 1'b1;

        // Single VGA read
        vga_en = 1'b1; vga_addr = 18'h00010;
        tick();
        vga_en = 1'b0;
        repeat (3) tick();
        chk("t1_data", {16'b0, vga_data}, 32'hA5A5);

        // GPU write then read-back of the top address
        n_we_low = 0; n_oe_hi = 0;
        gpu_en = 1'b1; gpu_wr = 1'b1; gpu_addr = 18'h3FFFF; gpu_wdata = 16'h1234;
        tick();
        gpu_wr = 1'b0;
        tick();
        tick();
        gpu_en = 1'b0;
        repeat (3) tick();
        chk("t2_we_low_cycles", n_we_low, 1);
        chk("t2_dq_oe_cycles", n_oe_hi, 2);
        chk("t2_rdata", {16'b0, gpu_data}, 32'h1234);

        // Back-to-back VGA reads of 16 addresses
        vga_en = 1'b1; vga_addr = 18'h01000; i = 0; t = 0; v0 = n_vval;
        while (i < 16 && t < 40) begin
            tick();
            t++;
            if (acc_v) begin
                i++;
                vga_addr = 18'h01000 + AW'(i);
            end
        end
        vga_en = 1'b0;
        repeat (3) tick();
        chk("t3_accepts", i, 16);
        chk("t3_cycles", t, 31);
        chk("t3_valids", n_vval - v0, 16);

        // Both requesting continuously for 100 slots
        vga_en = 1'b1; gpu_en = 1'b1; gpu_wr = 1'b0; g0 = n_gacc;
        repeat (200) begin
            tick();
            if (acc_v) vga_addr = AW'($urandom);
            if (acc_g) gpu_addr = AW'($urandom);
        end
        vga_en = 1'b0; gpu_en = 1'b0;
        repeat (3) tick();
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
        chk("t4_gpu_accepts", n_gacc - g0, 11);
`else
        chk("t4_gpu_accepts", n_gacc - g0, 0);
`endif

        // Random mixed traffic, requests held until accepted
        repeat (400) begin
            tick();
            if (!vga_en || acc_v) begin
                vga_en = ($urandom % 3) != 0;
                vga_addr = AW'($urandom % 64);
            end
            if (!gpu_en || acc_g) begin
                gpu_en = ($urandom % 2) != 0;
                gpu_wr = $urandom % 2;
                gpu_addr = AW'($urandom % 64);
                gpu_wdata = DW'($urandom);
            end
        end
        vga_en = 1'b0; gpu_en = 1'b0;
        repeat (4) tick();

        // Reset asserted during the ACC cycle of a write
        gpu_en = 1'b1; gpu_wr = 1'b1; gpu_addr = 18'h00777; gpu_wdata = 16'hBEEF;
        old = ref_rd(gpu_addr);
        tick();
        vga_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we_n", {31'b0, we_n}, 1);
        chk("arst_dq_oe", {31'b0, s_oe}, 0);
        chk("arst_ce_n", {31'b0, ce_n}, 1);
        chk("arst_rdy", {30'b0, vga_rdy, gpu_rdy}, 0);
        ref_mem[32'h777] = old;
        sb.delete();
        streak = 0;
        la_cycle = -1000;
        @(posedge clk); #1;
        chk("arst_valids", {30'b0, vga_val, gpu_val}, 0);
        vga_en = 1'b0; gpu_en = 1'b0;
        rst_n = 1'b1;
        vga_en = 1'b1; vga_addr = 18'h00020; v0 = n_vval;
        tick();
        vga_en = 1'b0;
        repeat (3) tick();
        chk("post_rst_valids", n_vval - v0, 1);
        chk("post_rst_pad", {16'b0, pad_rd(18'h00777)}, {16'b0, old});
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
